mem_stream_responder: RTL and testbench
=======================================

// Module: mem_stream_responder
// PURPOSE
// - Memory-side responder for the valid/ready mem request + valid-only mem response interface.
// - Accepts one request per cycle into an internal word-addressed SRAM model with fixed read latency.
// - Returns exactly one in-order response per accepted request, for both reads and writes.
// - Zero-initialises the array after every reset before it accepts traffic.
// - Used as a local scratchpad behind any stream-to-memory initiator.
// PARAMETERS
// - NumWords   256  array depth in words (>=2)
// - DataWidth  32   word width, multiple of 8
// - AddrWidth  32   word address width (>= $clog2(NumWords))
// - Latency    1    cycles from request handshake to response valid (>=1)
// PORTS
// - clk_i             in   1           clock
// - rst_ni            in   1           asynchronous active-low reset
// - mem_req_addr_i    in   AddrWidth   word address
// - mem_req_we_i      in   1           1 = write, 0 = read
// - mem_req_be_i      in   DataWidth/8 byte enables (writes only)
// - mem_req_wdata_i   in   DataWidth   write data
// - mem_req_valid_i   in   1           request valid
// - mem_req_ready_o   out  1           request ready
// - mem_resp_rdata_o  out  DataWidth   read data (0 for writes)
// - mem_resp_err_o    out  1           error flag (MEM_STREAM_RESP_ERR_EN only, else tied 0)
// - mem_resp_valid_o  out  1           response valid; no ready, initiator must reserve space
// - init_done_o       out  1           array initialised, block in RUN
// BEHAVIOUR
// Reset values
// - All outputs reset to 0.
// - Pipeline valid bits reset to 0.
// - FSM resets to INIT with init_idx = 0.
// FSM
// - INIT: write 0 to word init_idx with all byte enables, then increment init_idx.
//   mem_req_ready_o = 0 throughout INIT.
//   At init_idx == NumWords-1, transition to RUN on the next edge; INIT lasts exactly NumWords cycles.
// - RUN: mem_req_ready_o = 1 and init_done_o = 1 every cycle. The FSM never leaves RUN except via reset.
// Handshake
// - A request is accepted when mem_req_valid_i & mem_req_ready_o.
// - A request accepted in cycle n gives mem_resp_valid_o = 1 in cycle n+Latency, for exactly one cycle.
// - Responses are strictly in request order. Throughput is 1 request/cycle with no bubbles.
// Writes
// - Update only the enabled bytes at the accept edge.
// - Response rdata = 0, err = 0.
// Reads
// - The array is sampled at the accept edge, then delayed through Latency-1 register stages.
// - A write accepted in cycle n is visible to a read accepted in cycle n+1 (no bypass needed).
// Addressing
// - Index = mem_req_addr_i[$clog2(NumWords)-1:0].
// - Upper bits are ignored when the macro is off.
// Outputs while idle
// - mem_resp_rdata_o and mem_resp_err_o are 0 whenever mem_resp_valid_o = 0.
// Reset mid-operation
// - In-flight responses are dropped: valid bits clear asynchronously.
// - The FSM returns to INIT and re-zeroes the whole array.
// - Array contents before init completes are undefined to the outside, since no reads are accepted then.
// - If valid is held during INIT, the request stays pending and is accepted in the first RUN cycle.
// CONFIGURATION
// - Macro MEM_STREAM_RESP_ERR_EN.
// - Defined: any request with mem_req_addr_i >= NumWords is accepted normally but does not touch the array.
//   Its response has err = 1, rdata = 0, and the same latency and ordering as any other response.
// - Undefined: no range check, addresses alias modulo NumWords, mem_resp_err_o is tied to 0.
// STRUCTURE
// - Package mem_stream_pkg: state enum {INIT, RUN}, typedef resp_meta_t {valid, we, err}.
// - One sub-module mem_stream_sram: behavioural byte-enabled array, 1 read/write port,
//   parameterised by NumWords, DataWidth and Latency.
//   It contains the Latency-1 output register stages.
// - The top level holds the FSM, init counter, range check and response metadata shift register.
// TESTING
// - Reset, then idle: ready = 0 for exactly 256 cycles, then init_done_o = 1 and ready = 1.
//   Then read addr 0..255: every rdata = 0.
// - Write addr 5 = 0xDEADBEEF with be = 4'b1111, then next cycle write addr 5 = 0x00001200 with be = 4'b0010.
//   Then read addr 5 -> rdata = 0xDEAD12EF.
//   Writes return rdata = 0, each response at accept + Latency.
// - Back-to-back: 64 reads with valid held high -> 64 consecutive responses, no gaps.
//   Order matches the request sequence. Repeat with Latency = 3.
// - Hold valid during INIT with a read of addr 7 -> accepted in cycle 256.
//   Response in cycle 256+Latency with rdata = 0.
// - Assert rst_ni mid-stream with 2 responses in flight.
//   -> resp_valid drops immediately, no late responses, INIT restarts.
//   A previously written word reads 0 afterwards.
// - With MEM_STREAM_RESP_ERR_EN: read addr 300 -> err = 1, rdata = 0, word 44 unchanged.
//   Write addr 256 -> err = 1, word 0 unchanged.
//   Without the macro: addr 300 aliases to word 44.

Source files
------------

// File: rtl/mem_stream_pkg.sv
// Shared types for the mem_stream_responder scratchpad: FSM states and
// the per-request metadata that travels alongside the SRAM read pipeline.
package mem_stream_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic valid;
    logic we;
    logic err;
  } resp_meta_t;

endpackage

// File: rtl/mem_stream_responder_if.sv
// Valid/ready memory request channel plus valid-only response channel.
// The initiator side uses the master modport, the responder uses slave.
interface mem_stream_responder_if #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32
);

  logic [AddrWidth-1:0]   mem_req_addr;
  logic                   mem_req_we;
  logic [DataWidth/8-1:0] mem_req_be;
  logic [DataWidth-1:0]   mem_req_wdata;
  logic                   mem_req_valid;
  logic                   mem_req_ready;
  logic [DataWidth-1:0]   mem_resp_rdata;
  logic                   mem_resp_err;
  logic                   mem_resp_valid;

  modport master (
    output mem_req_addr, mem_req_we, mem_req_be, mem_req_wdata, mem_req_valid,
    input  mem_req_ready, mem_resp_rdata, mem_resp_err, mem_resp_valid
  );

  modport slave (
    input  mem_req_addr, mem_req_we, mem_req_be, mem_req_wdata, mem_req_valid,
    output mem_req_ready, mem_resp_rdata, mem_resp_err, mem_resp_valid
  );

endinterface

// File: rtl/mem_stream_sram.sv
// Behavioural single-port byte-enabled array. The read is sampled at the
// request edge and then delayed so rdata_o lands Latency cycles later.
module mem_stream_sram #(
  parameter int NumWords  = 256,
  parameter int DataWidth = 32,
  parameter int Latency   = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         we_i,
  input  logic [DataWidth/8-1:0]       be_i,
  input  logic [$clog2(NumWords)-1:0]  idx_i,
  input  logic [DataWidth-1:0]         wdata_i,
  output logic [DataWidth-1:0]         rdata_o
);

  localparam int NumBytes = DataWidth / 8;

  logic [DataWidth-1:0] mem_q   [NumWords];
  logic [DataWidth-1:0] rdata_q [Latency];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < NumBytes; b++) begin
        if (be_i[b]) begin
          mem_q[idx_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
  end

  // Stage 0 samples the array; the remaining Latency-1 stages only delay it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Latency; i++) begin
        rdata_q[i] <= '0;
      end
    end else begin
      rdata_q[0] <= mem_q[idx_i];
      for (int i = 1; i < Latency; i++) begin
        rdata_q[i] <= rdata_q[i-1];
      end
    end
  end

  assign rdata_o = rdata_q[Latency-1];

endmodule

// File: rtl/mem_stream_responder.sv
// Scratchpad responder: zeroes the array after reset, then serves one request per cycle
// with in-order responses. Optional range check enabled by MEM_STREAM_RESP_ERR_EN.
module mem_stream_responder
  import mem_stream_pkg::*;
#(
  parameter int NumWords  = 256,
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32,
  parameter int Latency   = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  mem_stream_responder_if.slave  mem,
  output logic                   init_done_o
);

  localparam int IdxWidth = $clog2(NumWords);
  localparam int NumBytes = DataWidth / 8;

  state_e                state_q, state_d;
  logic [IdxWidth-1:0]   init_idx_q, init_idx_d;
  resp_meta_t            meta_q [Latency];
  resp_meta_t            meta_in, resp;
  logic                  accept;
  logic                  in_range;
  logic                  sram_we;
  logic [NumBytes-1:0]   sram_be;
  logic [IdxWidth-1:0]   sram_idx;
  logic [DataWidth-1:0]  sram_wdata;
  logic [DataWidth-1:0]  sram_rdata;

`ifdef MEM_STREAM_RESP_ERR_EN
  assign in_range = ({1'b0, mem.mem_req_addr} < (AddrWidth+1)'(NumWords));
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^mem.mem_req_addr;
  assign in_range         = 1'b1;
`endif

  assign accept = mem.mem_req_valid & (state_q == RUN);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= INIT;
      init_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    if (state_q == INIT) begin
      init_idx_d = init_idx_q + IdxWidth'(1);
      if (init_idx_q == IdxWidth'(NumWords - 1)) begin
        state_d    = RUN;
        init_idx_d = '0;
      end
    end
  end

  // While initialising, the array port is owned by the zeroing sweep.
  always_comb begin
    mem.mem_req_ready = 1'b0;
    init_done_o       = 1'b0;
    sram_we           = 1'b1;
    sram_be           = '1;
    sram_idx          = init_idx_q;
    sram_wdata        = '0;
    if (state_q == RUN) begin
      mem.mem_req_ready = 1'b1;
      init_done_o       = 1'b1;
      sram_we           = mem.mem_req_valid & mem.mem_req_we & in_range;
      sram_be           = mem.mem_req_be;
      sram_idx          = mem.mem_req_addr[IdxWidth-1:0];
      sram_wdata        = mem.mem_req_wdata;
    end
  end

  always_comb begin
    meta_in       = '0;
    meta_in.valid = accept;
    meta_in.we    = mem.mem_req_we;
    meta_in.err   = ~in_range;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Latency; i++) begin
        meta_q[i] <= '0;
      end
    end else begin
      meta_q[0] <= meta_in;
      for (int i = 1; i < Latency; i++) begin
        meta_q[i] <= meta_q[i-1];
      end
    end
  end

  mem_stream_sram #(
    .NumWords  (NumWords),
    .DataWidth (DataWidth),
    .Latency   (Latency)
  ) u_sram (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (sram_we),
    .be_i    (sram_be),
    .idx_i   (sram_idx),
    .wdata_i (sram_wdata),
    .rdata_o (sram_rdata)
  );

  // Response data is only exposed for successful reads, otherwise held at zero.
  assign resp               = meta_q[Latency-1];
  assign mem.mem_resp_valid = resp.valid;
  assign mem.mem_resp_rdata = (resp.valid & ~resp.we & ~resp.err) ? sram_rdata : '0;
`ifdef MEM_STREAM_RESP_ERR_EN
  assign mem.mem_resp_err   = resp.valid & resp.err;
`else
  assign mem.mem_resp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stream_responder.sv
// Scoreboard bench for mem_stream_responder; drives Latency=1 and Latency=3 instances
// with identical traffic and checks both against a word-array reference model.
module tb_mem_stream_responder;

  localparam int NumWords = 256;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic [31:0] reqAddr = '0;
  logic [31:0] reqWdata = '0;
  logic [3:0]  reqBe = '0;
  logic        reqWe = 1'b0;
  logic        reqValid = 1'b0;
  logic        done1, done3;

  int numChecks = 0;
  int numFails = 0;
  int cyc = 0;
  int lastAcceptCyc = -1;

  logic [31:0] modelMem [NumWords];
  exp_t        q1[$];
  exp_t        q3[$];

  always #5 clk = ~clk;

  mem_stream_responder_if #(.AddrWidth(32), .DataWidth(32)) if1 ();
  mem_stream_responder_if #(.AddrWidth(32), .DataWidth(32)) if3 ();

  assign if1.mem_req_addr  = reqAddr;
  assign if1.mem_req_we    = reqWe;
  assign if1.mem_req_be    = reqBe;
  assign if1.mem_req_wdata = reqWdata;
  assign if1.mem_req_valid = reqValid;
  assign if3.mem_req_addr  = reqAddr;
  assign if3.mem_req_we    = reqWe;
  assign if3.mem_req_be    = reqBe;
  assign if3.mem_req_wdata = reqWdata;
  assign if3.mem_req_valid = reqValid;

  mem_stream_responder #(
    .NumWords(NumWords), .DataWidth(32), .AddrWidth(32), .Latency(1)
  ) dut1 (
    .clk_i       (clk),
    .rst_ni      (rstN),
    .mem         (if1),
    .init_done_o (done1)
  );

  mem_stream_responder #(
    .NumWords(NumWords), .DataWidth(32), .AddrWidth(32), .Latency(3)
  ) dut3 (
    .clk_i       (clk),
    .rst_ni      (rstN),
    .mem         (if3),
    .init_done_o (done3)
  );

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    numChecks++;
    if (act !== exp) begin
      numFails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Pops the response due this cycle (if any) and compares, otherwise expects idle zeros.
  task automatic checkOutput(input int lat, input logic vld, input logic [31:0] rdata, input logic err);
    exp_t e;
    bit   have;
    have = 1'b0;
    if (lat == 1) begin
      if (q1.size() > 0 && q1[0].cyc <= cyc) begin
        e = q1.pop_front();
        have = 1'b1;
      end
    end else begin
      if (q3.size() > 0 && q3[0].cyc <= cyc) begin
        e = q3.pop_front();
        have = 1'b1;
      end
    end
    if (have) begin
      checkValue($sformatf("resp_valid L%0d cyc %0d", lat, cyc), {31'b0, vld}, 32'd1);
      if (vld) begin
        checkValue($sformatf("resp_rdata L%0d cyc %0d", lat, cyc), rdata, e.rdata);
        checkValue($sformatf("resp_err L%0d cyc %0d", lat, cyc), {31'b0, err}, {31'b0, e.err});
      end
    end else begin
      checkValue($sformatf("idle valid L%0d cyc %0d", lat, cyc), {31'b0, vld}, 32'd0);
      checkValue($sformatf("idle rdata L%0d cyc %0d", lat, cyc), rdata, 32'd0);
      checkValue($sformatf("idle err L%0d cyc %0d", lat, cyc), {31'b0, err}, 32'd0);
    end
  endtask

  task automatic modelAccept();
    exp_t e;
    int   idx;
    bit   inRange;
`ifdef MEM_STREAM_RESP_ERR_EN
    inRange = (reqAddr < NumWords);
`else
    inRange = 1'b1;
`endif
    idx     = int'(reqAddr % NumWords);
    e.err   = !inRange;
    e.rdata = '0;
    if (inRange) begin
      if (reqWe) begin
        for (int b = 0; b < 4; b++) begin
          if (reqBe[b]) modelMem[idx][b*8 +: 8] = reqWdata[b*8 +: 8];
        end
      end else begin
        e.rdata = modelMem[idx];
      end
    end
    lastAcceptCyc = cyc;
    e.cyc = cyc + 1;
    q1.push_back(e);
    e.cyc = cyc + 3;
    q3.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rstN) begin
      cyc = 0;
      q1.delete();
      q3.delete();
      for (int i = 0; i < NumWords; i++) modelMem[i] = '0;
      checkValue("reset valid L1", {31'b0, if1.mem_resp_valid}, 32'd0);
      checkValue("reset valid L3", {31'b0, if3.mem_resp_valid}, 32'd0);
      checkValue("reset ready L1", {31'b0, if1.mem_req_ready}, 32'd0);
      checkValue("reset done L3", {31'b0, done3}, 32'd0);
      checkValue("reset rdata L3", if3.mem_resp_rdata, 32'd0);
    end else begin
      checkOutput(1, if1.mem_resp_valid, if1.mem_resp_rdata, if1.mem_resp_err);
      checkOutput(3, if3.mem_resp_valid, if3.mem_resp_rdata, if3.mem_resp_err);
      checkValue($sformatf("ready L1 cyc %0d", cyc), {31'b0, if1.mem_req_ready}, {31'b0, cyc >= NumWords});
      checkValue($sformatf("ready L3 cyc %0d", cyc), {31'b0, if3.mem_req_ready}, {31'b0, cyc >= NumWords});
      checkValue($sformatf("init_done L1 cyc %0d", cyc), {31'b0, done1}, {31'b0, cyc >= NumWords});
      checkValue($sformatf("init_done L3 cyc %0d", cyc), {31'b0, done3}, {31'b0, cyc >= NumWords});
      if (reqValid && cyc >= NumWords) modelAccept();
      cyc++;
    end
  end

  task automatic applyStimulus(input logic [31:0] addr, input logic we, input logic [3:0] be,
                               input logic [31:0] wdata, output int acceptCyc);
    int waitCnt;
    waitCnt  = 0;
    reqAddr  = addr;
    reqWe    = we;
    reqBe    = be;
    reqWdata = wdata;
    reqValid = 1'b1;
    @(negedge clk);
    while (!(rstN && if1.mem_req_ready) && waitCnt < 600) begin
      @(negedge clk);
      waitCnt++;
    end
    @(posedge clk);
    #1;
    reqValid = 1'b0;
    if (waitCnt >= 600) begin
      numChecks++;
      numFails++;
      $display("[TB] FAIL accept timeout addr %h: got no ready, expected ready within 600 cycles", addr);
      acceptCyc = -1;
    end else begin
      acceptCyc = lastAcceptCyc;
    end
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation still running at 1 ms, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc;
    rstN = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstN = 1'b1;

    // Read held valid through INIT: accepted in the first RUN cycle.
    applyStimulus(32'd7, 1'b0, 4'h0, 32'h0, acc);
    checkValue("init-held read accept cycle", acc, 32'd256);

    for (int i = 0; i < NumWords; i++) applyStimulus(i, 1'b0, 4'h0, 32'h0, acc);

    applyStimulus(32'd5, 1'b1, 4'b1111, 32'hDEADBEEF, acc);
    applyStimulus(32'd5, 1'b1, 4'b0010, 32'h00001200, acc);
    applyStimulus(32'd5, 1'b0, 4'h0, 32'h0, acc);

    applyStimulus(32'd44, 1'b1, 4'hF, 32'hA5A50044, acc);
    applyStimulus(32'd300, 1'b0, 4'h0, 32'h0, acc);
    applyStimulus(32'd44, 1'b0, 4'h0, 32'h0, acc);
    applyStimulus(32'd0, 1'b1, 4'hF, 32'h0BAD0000, acc);
    applyStimulus(32'd256, 1'b1, 4'hF, 32'hFFFFFFFF, acc);
    applyStimulus(32'd0, 1'b0, 4'h0, 32'h0, acc);

    for (int i = 0; i < 64; i++) applyStimulus($urandom_range(0, 255), 1'b0, 4'h0, 32'h0, acc);

    for (int i = 0; i < 300; i++) begin
      applyStimulus($urandom_range(0, 511), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    $urandom, acc);
      if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 2));
    end

    // Reset with responses still in the pipeline, then confirm the array was re-zeroed.
    applyStimulus(32'd9, 1'b1, 4'hF, 32'h12345678, acc);
    idleCycles(4);
    applyStimulus(32'd9, 1'b0, 4'h0, 32'h0, acc);
    applyStimulus(32'd9, 1'b0, 4'h0, 32'h0, acc);
    rstN = 1'b0;
    idleCycles(3);
    rstN = 1'b1;
    applyStimulus(32'd9, 1'b0, 4'h0, 32'h0, acc);
    checkValue("post-reset read accept cycle", acc, 32'd256);
    applyStimulus(32'd5, 1'b0, 4'h0, 32'h0, acc);

    idleCycles(10);
    checkValue("L1 pending responses at end", q1.size(), 32'd0);
    checkValue("L3 pending responses at end", q3.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", numChecks, numFails);
    $finish;
  end

endmodule
